// File: rtl/lcd_pkg.sv
// Shared constants, state type and the column-to-bit mapping for the 16x2 LCD text path.
package lcd_pkg;

  localparam int LCD_COLS = 16;
  localparam int LCD_ROWS = 2;
  localparam logic [7:0] LCD_FILL_CHAR = 8'h20;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;

  // Column 0 sits in the most significant byte of a line buffer.
  function automatic int col_offset(input logic [3:0] c);
    return (LCD_COLS - 1 - int'(c)) * 8;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic N-way round-robin arbiter; the search starts at rr_ptr, which moves past the winner on advance.
module rr_arbiter #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  input  logic [PW-1:0] adv_idx,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);

  logic [PW-1:0] rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= PW'((int'(adv_idx) + 1) % N);
    end
  end

  always_comb begin
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int off = 0; off < N; off++) begin
      int cand;
      cand = (int'(rr_ptr) + off) % N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/lcd_text_arb.sv
// Owns both LCD line buffers, arbitrates character writers round-robin and sequences a 32-cycle clear.
// Optional per-requester grant counters are enabled with LCD_TEXT_ARB_STATS_EN.
module lcd_text_arb
  import lcd_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter logic [7:0] FILL_CHAR = LCD_FILL_CHAR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ-1:0]     req_row,
  input  logic [4*NUM_REQ-1:0]   req_col,
  input  logic [8*NUM_REQ-1:0]   req_char,
  input  logic                   clear_start,
  output logic                   busy,
  output logic [LCD_COLS*8-1:0]  line1_buffer,
  output logic [LCD_COLS*8-1:0]  line2_buffer
`ifdef LCD_TEXT_ARB_STATS_EN
  ,
  output logic [16*NUM_REQ-1:0]  grant_cnt
`endif
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t state, state_nxt;
  logic [4:0] clr_cnt, clr_cnt_nxt;
  logic [NUM_REQ-1:0] arb_req, arb_grant;
  logic [PW-1:0] arb_idx;
  logic       sel_row;
  logic [3:0] sel_col;
  logic [7:0] sel_char;

  // A clear request or an active clear masks every requester before arbitration.
  assign arb_req   = (state == RUN && !clear_start) ? req_valid : '0;
  assign req_ready = arb_grant;
  assign busy      = (state == CLEAR);

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (arb_req),
    .advance   (|arb_grant),
    .adv_idx   (arb_idx),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign sel_row  = req_row[arb_idx];
  assign sel_col  = req_col[int'(arb_idx)*4 +: 4];
  assign sel_char = req_char[int'(arb_idx)*8 +: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      RUN: begin
        if (clear_start) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      CLEAR: begin
        clr_cnt_nxt = clr_cnt + 5'd1;
        if (clr_cnt == 5'd31) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Counter bit 4 picks the line, low bits the column.
  always_ff @(posedge clk) begin
    if (rst) begin
      line1_buffer <= {LCD_COLS{FILL_CHAR}};
      line2_buffer <= {LCD_COLS{FILL_CHAR}};
    end else if (state == CLEAR) begin
      if (clr_cnt[4]) line2_buffer[col_offset(clr_cnt[3:0]) +: 8] <= FILL_CHAR;
      else            line1_buffer[col_offset(clr_cnt[3:0]) +: 8] <= FILL_CHAR;
    end else if (|arb_grant) begin
      if (sel_row) line2_buffer[col_offset(sel_col) +: 8] <= sel_char;
      else         line1_buffer[col_offset(sel_col) +: 8] <= sel_char;
    end
  end

`ifdef LCD_TEXT_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (arb_grant[i] && grant_cnt[i*16 +: 16] != 16'hFFFF)
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lcd_text_arb.sv
// Directed self-checking bench for lcd_text_arb (two requesters); covers LCD_TEXT_ARB_STATS_EN when defined.
module tb_lcd_text_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_row;
  logic [7:0]   req_col;
  logic [15:0]  req_char;
  logic         clear_start;
  logic         busy;
  logic [127:0] line1_buffer;
  logic [127:0] line2_buffer;
`ifdef LCD_TEXT_ARB_STATS_EN
  logic [31:0]  grant_cnt;
`endif

  int total = 0;
  int bad = 0;
  logic [127:0] exp1, exp2;
  localparam logic [127:0] SPACES = {16{8'h20}};

  always #5 clk = ~clk;

  lcd_text_arb #(.NUM_REQ(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_row      (req_row),
    .req_col      (req_col),
    .req_char     (req_char),
    .clear_start  (clear_start),
    .busy         (busy),
    .line1_buffer (line1_buffer),
`ifdef LCD_TEXT_ARB_STATS_EN
    .line2_buffer (line2_buffer),
    .grant_cnt    (grant_cnt)
`else
    .line2_buffer (line2_buffer)
`endif
  );

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [1:0] row,
                               input logic [7:0] col, input logic [15:0] ch, input logic clr);
    req_valid   = v;
    req_row     = row;
    req_col     = col;
    req_char    = ch;
    clear_start = clr;
    #1;
  endtask

  task automatic putExp(input logic row, input logic [3:0] col, input logic [7:0] ch);
    if (row) exp2[(15 - int'(col))*8 +: 8] = ch;
    else     exp1[(15 - int'(col))*8 +: 8] = ch;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(2'b00, 2'b00, 8'h00, 16'h0000, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    exp1 = SPACES;
    exp2 = SPACES;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bcount;
    doReset();
    checkOutput("reset_line1", line1_buffer, SPACES);
    checkOutput("reset_line2", line2_buffer, SPACES);
    checkOutput("reset_busy", {127'd0, busy}, 128'd0);
    checkOutput("reset_ready", {126'd0, req_ready}, 128'd0);

    // Two single writes from requester 0.
    applyStimulus(2'b01, 2'b00, 8'h00, 16'h0048, 1'b0);
    checkOutput("h_ready", {126'd0, req_ready}, 128'd1);
    tick();
    checkOutput("h_byte", {120'd0, line1_buffer[127:120]}, 128'h48);
    applyStimulus(2'b01, 2'b01, 8'h0F, 16'h0021, 1'b0);
    checkOutput("bang_ready", {126'd0, req_ready}, 128'd1);
    tick();
    checkOutput("bang_byte", {120'd0, line2_buffer[7:0]}, 128'h21);
    checkOutput("h_kept", {120'd0, line1_buffer[127:120]}, 128'h48);

    // Alternation from a fresh reset; req0 -> row0 col1 'a', req1 -> row1 col2 'b'.
    doReset();
    applyStimulus(2'b11, 2'b10, 8'h21, 16'h6261, 1'b0);
    for (int i = 0; i < 6; i++) begin
      logic [1:0] expg;
      expg = (i % 2 == 0) ? 2'b01 : 2'b10;
      checkOutput($sformatf("alt_%0d", i), {126'd0, req_ready}, {126'd0, expg});
      if (expg[0]) putExp(1'b0, 4'd1, 8'h61);
      else         putExp(1'b1, 4'd2, 8'h62);
      tick();
    end
    checkOutput("alt_line1", line1_buffer, exp1);
    checkOutput("alt_line2", line2_buffer, exp2);

    // Requester 0 idle must not stall requester 1.
    applyStimulus(2'b10, 2'b10, 8'h21, 16'h6261, 1'b0);
    checkOutput("skip_a", {126'd0, req_ready}, 128'd2);
    tick();
    checkOutput("skip_b", {126'd0, req_ready}, 128'd2);
    tick();
    applyStimulus(2'b01, 2'b10, 8'h21, 16'h6261, 1'b0);
    checkOutput("skip_c", {126'd0, req_ready}, 128'd1);
    tick();
    applyStimulus(2'b11, 2'b10, 8'h21, 16'h6261, 1'b0);
    checkOutput("skip_d", {126'd0, req_ready}, 128'd2);
    tick();

    // Clear collides with req1 valid.
    applyStimulus(2'b10, 2'b10, 8'h21, 16'h6261, 1'b1);
    checkOutput("clr_noready", {126'd0, req_ready}, 128'd0);
    tick();
    applyStimulus(2'b10, 2'b10, 8'h21, 16'h6261, 1'b0);
    checkOutput("clr_busy", {127'd0, busy}, 128'd1);
    bcount = 0;
    while (busy && bcount < 40) begin
      if (bcount == 5) checkOutput("clr_ready_mid", {126'd0, req_ready}, 128'd0);
      bcount++;
      tick();
    end
    checkOutput("clr_len", 128'(bcount), 128'd32);
    checkOutput("clr_line1", line1_buffer, SPACES);
    checkOutput("clr_line2", line2_buffer, SPACES);
    checkOutput("post_clr_ready", {126'd0, req_ready}, 128'd2);
    exp1 = SPACES;
    exp2 = SPACES;
    putExp(1'b1, 4'd2, 8'h62);
    tick();
    applyStimulus(2'b00, 2'b10, 8'h21, 16'h6261, 1'b0);
    checkOutput("post_clr_line2", line2_buffer, exp2);

    // Write 'A' to three cells, then reset at clear count 10.
    applyStimulus(2'b01, 2'b00, 8'h03, 16'h0041, 1'b0);
    tick();
    applyStimulus(2'b01, 2'b01, 8'h07, 16'h0041, 1'b0);
    tick();
    applyStimulus(2'b01, 2'b00, 8'h0F, 16'h0041, 1'b0);
    tick();
    putExp(1'b0, 4'd3, 8'h41);
    putExp(1'b1, 4'd7, 8'h41);
    putExp(1'b0, 4'd15, 8'h41);
    checkOutput("a_line1", line1_buffer, exp1);
    checkOutput("a_line2", line2_buffer, exp2);
    applyStimulus(2'b00, 2'b00, 8'h00, 16'h0000, 1'b1);
    tick();
    applyStimulus(2'b00, 2'b00, 8'h00, 16'h0000, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("mid_busy", {127'd0, busy}, 128'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_mid_line1", line1_buffer, SPACES);
    checkOutput("rst_mid_line2", line2_buffer, SPACES);
    checkOutput("rst_mid_busy", {127'd0, busy}, 128'd0);
    applyStimulus(2'b01, 2'b00, 8'h05, 16'h0030, 1'b0);
    checkOutput("rst_mid_run", {126'd0, req_ready}, 128'd1);
    applyStimulus(2'b00, 2'b00, 8'h00, 16'h0000, 1'b0);

`ifdef LCD_TEXT_ARB_STATS_EN
    applyStimulus(2'b01, 2'b00, 8'h04, 16'h0031, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    applyStimulus(2'b10, 2'b00, 8'h40, 16'h3200, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    applyStimulus(2'b00, 2'b00, 8'h00, 16'h0000, 1'b1);
    tick();
    applyStimulus(2'b00, 2'b00, 8'h00, 16'h0000, 1'b0);
    bcount = 0;
    while (busy && bcount < 40) begin
      bcount++;
      tick();
    end
    checkOutput("stats_clr_len", 128'(bcount), 128'd32);
    checkOutput("stats_cnt", {96'd0, grant_cnt}, {96'd0, 16'd3, 16'd5});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
